// File: rtl/alu_pkg.sv
// Shared opcode constants and controller state type for the sequential ALU.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_HOLD
    } alu_state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle of the sequential ALU: valid/ready on both sides,
// operands and opcode in, registered result and flags out.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             negative;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, carry, zero, negative, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, carry, zero, negative, overflow
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier; the load edge already performs the first
// partial-product step, so WIDTH steps finish WIDTH-1 edges after start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] a_ext;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               running;

    assign a_ext = {{WIDTH{1'b0}}, a};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= b[0] ? a_ext : '0;
            mcand   <= a_ext << 1;
            mplier  <= b >> 1;
            count   <= CW'(WIDTH - 1);
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count - CW'(1);
            end
        end
    end

    assign done    = running && (count == '0);
    assign product = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops land in the output register on the accept
// edge; MUL runs through the iterative multiplier before being held.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    localparam int SW = $clog2(WIDTH);

    alu_state_t         state;
    alu_state_t         state_next;
    logic               out_valid;
    logic               in_ready;
    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_done;
    logic               load;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH:0]     shl_wide;
    logic [WIDTH:0]     shr_wide;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   res_next;
    logic [WIDTH-1:0]   result_q;
    logic               alu_carry;
    logic               alu_ovf;
    logic               carry_next;
    logic               ovf_next;
    logic               carry_q;
    logic               zero_q;
    logic               negative_q;
    logic               overflow_q;

    assign out_valid = (state == ST_HOLD);
    assign in_ready  = (state != ST_BUSY) && (!out_valid || bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = (bus.op == ALU_MUL);

    // One spare bit on each shift catches the last bit shifted out (0 for amount 0)
    assign shamt    = bus.b[SW-1:0];
    assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff     = {1'b0, bus.a} - {1'b0, bus.b};
    assign shl_wide = {1'b0, bus.a} << shamt;
    assign shr_wide = {bus.a, 1'b0} >> shamt;

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                alu_res   = sum[WIDTH-1:0];
                alu_carry = sum[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res   = diff[WIDTH-1:0];
                alu_carry = diff[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            ALU_AND: alu_res = bus.a & bus.b;
            ALU_XOR: alu_res = bus.a ^ bus.b;
            ALU_OR:  alu_res = bus.a | bus.b;
            ALU_SHL: begin
                alu_res   = shl_wide[WIDTH-1:0];
                alu_carry = shl_wide[WIDTH];
            end
            ALU_SHR: begin
                alu_res   = shr_wide[WIDTH:1];
                alu_carry = shr_wide[0];
            end
            default: ;
        endcase
    end

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mul_start),
        .a      (bus.a),
        .b      (bus.b),
        .done   (mul_done),
        .product(mul_product)
    );

    always_comb begin
        state_next = state;
        mul_start  = 1'b0;
        load       = 1'b0;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    if (is_mul) begin
                        state_next = ST_BUSY;
                        mul_start  = 1'b1;
                    end else begin
                        state_next = ST_HOLD;
                        load       = 1'b1;
                    end
                end else if (out_valid && bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_done) begin
                    state_next = ST_HOLD;
                    load       = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        res_next   = alu_res;
        carry_next = alu_carry;
        ovf_next   = alu_ovf;
        if (state == ST_BUSY) begin
            res_next   = mul_product[WIDTH-1:0];
            carry_next = |mul_product[2*WIDTH-1:WIDTH];
            ovf_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flags are registered with the result so reset can clear zero as well
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
        end else if (load) begin
            result_q   <= res_next;
            carry_q    <= carry_next;
            zero_q     <= (res_next == '0);
            negative_q <= res_next[WIDTH-1];
            overflow_q <= ovf_next;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.result    = result_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = negative_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH 8, 2 and 16: directed cases on the 8-bit unit,
// then random streams on all three against an arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        logic [31:0] res;
        logic        carry;
        logic        ovf;
    } calc_t;

    typedef struct {
        bit     valid;
        calc_t  val;
        longint due;
    } slot_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_d  [NDUT];
    logic        out_ready_d [NDUT];
    logic [31:0] a_d         [NDUT];
    logic [31:0] b_d         [NDUT];
    logic [2:0]  op_d        [NDUT];
    logic        in_ready_o  [NDUT];
    logic        out_valid_o [NDUT];
    logic        carry_o     [NDUT];
    logic        zero_o      [NDUT];
    logic        neg_o       [NDUT];
    logic        ovf_o       [NDUT];
    logic [31:0] result_o    [NDUT];
    slot_t       model       [NDUT];
    longint      cycle = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          exp_ov;
    bit          exp_busy;
    bit          exp_ir;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  if8 ();
    alu_seq_if #(.WIDTH(2))  if2 ();
    alu_seq_if #(.WIDTH(16)) if16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    alu_seq #(.WIDTH(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(if2));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    assign if8.in_valid   = in_valid_d[0];
    assign if8.out_ready  = out_ready_d[0];
    assign if8.a          = a_d[0][7:0];
    assign if8.b          = b_d[0][7:0];
    assign if8.op         = op_d[0];
    assign in_ready_o[0]  = if8.in_ready;
    assign out_valid_o[0] = if8.out_valid;
    assign result_o[0]    = 32'(if8.result);
    assign carry_o[0]     = if8.carry;
    assign zero_o[0]      = if8.zero;
    assign neg_o[0]       = if8.negative;
    assign ovf_o[0]       = if8.overflow;

    assign if2.in_valid   = in_valid_d[1];
    assign if2.out_ready  = out_ready_d[1];
    assign if2.a          = a_d[1][1:0];
    assign if2.b          = b_d[1][1:0];
    assign if2.op         = op_d[1];
    assign in_ready_o[1]  = if2.in_ready;
    assign out_valid_o[1] = if2.out_valid;
    assign result_o[1]    = 32'(if2.result);
    assign carry_o[1]     = if2.carry;
    assign zero_o[1]      = if2.zero;
    assign neg_o[1]       = if2.negative;
    assign ovf_o[1]       = if2.overflow;

    assign if16.in_valid  = in_valid_d[2];
    assign if16.out_ready = out_ready_d[2];
    assign if16.a         = a_d[2][15:0];
    assign if16.b         = b_d[2][15:0];
    assign if16.op        = op_d[2];
    assign in_ready_o[2]  = if16.in_ready;
    assign out_valid_o[2] = if16.out_valid;
    assign result_o[2]    = 32'(if16.result);
    assign carry_o[2]     = if16.carry;
    assign zero_o[2]      = if16.zero;
    assign neg_o[2]       = if16.negative;
    assign ovf_o[2]       = if16.overflow;

    function automatic int wid(input int idx);
        return (idx == 1) ? 2 : (idx == 2) ? 16 : 8;
    endfunction

    function automatic longint unsigned maskw(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference arithmetic on 64-bit integers, truncated to the unit's width
    function automatic calc_t calc(input int w, input logic [2:0] op,
                                   input logic [31:0] a_in, input logic [31:0] b_in);
        longint unsigned m = maskw(w);
        longint unsigned a = 64'(a_in) & m;
        longint unsigned b = 64'(b_in) & m;
        longint unsigned full;
        longint unsigned r;
        int              sh;
        bit              sa, sb, sr;
        calc_t           c;
        c.carry = 1'b0;
        c.ovf   = 1'b0;
        r       = 0;
        sh      = int'(b % 64'(w));
        case (op)
            ALU_ADD: begin
                full    = a + b;
                r       = full & m;
                c.carry = ((full >> w) & 64'd1) != 0;
            end
            ALU_SUB: begin
                r       = (a - b) & m;
                c.carry = a < b;
            end
            ALU_AND: r = a & b;
            ALU_XOR: r = a ^ b;
            ALU_OR:  r = a | b;
            ALU_SHL: begin
                r       = (a << sh) & m;
                c.carry = (sh != 0) && (((a >> (w - sh)) & 64'd1) != 0);
            end
            ALU_SHR: begin
                r       = a >> sh;
                c.carry = (sh != 0) && (((a >> (sh - 1)) & 64'd1) != 0);
            end
            default: begin
                full    = a * b;
                r       = full & m;
                c.carry = (full >> w) != 0;
            end
        endcase
        sa = ((a >> (w - 1)) & 64'd1) != 0;
        sb = ((b >> (w - 1)) & 64'd1) != 0;
        sr = ((r >> (w - 1)) & 64'd1) != 0;
        if (op == ALU_ADD) c.ovf = (sa == sb) && (sr != sa);
        if (op == ALU_SUB) c.ovf = (sa != sb) && (sr != sa);
        c.res = 32'(r);
        return c;
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s dut%0d @%0t: got 0x%0h, expected 0x%0h",
                     name, idx, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic valid, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b, input logic ordy);
        in_valid_d[idx]  = valid;
        op_d[idx]        = op;
        a_d[idx]         = a;
        b_d[idx]         = b;
        out_ready_d[idx] = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic driveRandom(input int idx, input bit allow_mul, input bit bursty);
        in_valid_d[idx]  = bursty ? ($urandom_range(0, 3) != 0) : 1'b1;
        op_d[idx]        = allow_mul ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
        a_d[idx]         = $urandom & 32'(maskw(wid(idx)));
        b_d[idx]         = $urandom & 32'(maskw(wid(idx)));
        out_ready_d[idx] = bursty ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Compare outputs mid-cycle, then advance the model by the coming edge's handshakes
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (!rst_n) begin
                model[i].valid = 1'b0;
                checkOutput("reset_out_valid", i, 32'(out_valid_o[i]), 32'd0);
                checkOutput("reset_result", i, result_o[i], 32'd0);
                checkOutput("reset_flags", i,
                            {28'd0, carry_o[i], zero_o[i], neg_o[i], ovf_o[i]}, 32'd0);
            end else begin
                exp_ov   = model[i].valid && (cycle >= model[i].due);
                exp_busy = model[i].valid && (cycle < model[i].due);
                exp_ir   = !exp_busy && (!exp_ov || out_ready_d[i]);
                checkOutput("out_valid", i, 32'(out_valid_o[i]), 32'(exp_ov));
                checkOutput("in_ready", i, 32'(in_ready_o[i]), 32'(exp_ir));
                if (exp_ov) begin
                    checkOutput("result", i, result_o[i], model[i].val.res);
                    checkOutput("flags_czvn", i,
                                {28'd0, carry_o[i], zero_o[i], neg_o[i], ovf_o[i]},
                                {28'd0, model[i].val.carry, model[i].val.res == 32'd0,
                                 model[i].val.res[wid(i)-1], model[i].val.ovf});
                end
                if (exp_ov && out_ready_d[i]) model[i].valid = 1'b0;
                if (in_valid_d[i] && exp_ir) begin
                    model[i].val   = calc(wid(i), op_d[i], a_d[i], b_d[i]);
                    model[i].valid = 1'b1;
                    model[i].due   = cycle + 1 + ((op_d[i] == ALU_MUL) ? wid(i) : 0);
                end
            end
        end
        cycle++;
    end

    initial begin
        calc_t c;
        for (int i = 0; i < NDUT; i++) begin
            in_valid_d[i]  = 1'b0;
            out_ready_d[i] = 1'b1;
            a_d[i]         = '0;
            b_d[i]         = '0;
            op_d[i]        = ALU_ADD;
            model[i].valid = 1'b0;
            model[i].due   = 0;
        end

        // Hand-computed values that pin the reference model
        c = calc(8, ALU_SHL, 32'h81, 32'h09);
        checkOutput("model_shl_mod", 0, {23'd0, c.carry, c.res[7:0]}, {23'd0, 1'b1, 8'h02});
        c = calc(8, ALU_SHR, 32'h81, 32'h01);
        checkOutput("model_shr", 0, {23'd0, c.carry, c.res[7:0]}, {23'd0, 1'b1, 8'h40});
        c = calc(16, ALU_MUL, 32'h1234, 32'h0100);
        checkOutput("model_mul16", 2, {15'd0, c.carry, c.res[15:0]}, {15'd0, 1'b1, 16'h3400});
        c = calc(2, ALU_ADD, 32'h1, 32'h1);
        checkOutput("model_add2", 1, {28'd0, c.ovf, c.carry, c.res[1:0]}, {28'd0, 1'b1, 1'b0, 2'b10});

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(0, 1'b1, ALU_ADD, 32'hFF, 32'h01, 1'b1);
        checkOutput("add_out_valid", 0, 32'(if8.out_valid), 32'd1);
        checkOutput("add_result", 0, 32'(if8.result), 32'h00);
        checkOutput("add_c_z_v", 0, {29'd0, if8.carry, if8.zero, if8.overflow}, {29'd0, 3'b110});

        applyStimulus(0, 1'b1, ALU_SUB, 32'h80, 32'h01, 1'b1);
        checkOutput("sub_ovf_result", 0, 32'(if8.result), 32'h7F);
        checkOutput("sub_ovf_c_v", 0, {30'd0, if8.carry, if8.overflow}, {30'd0, 2'b01});

        applyStimulus(0, 1'b1, ALU_SUB, 32'h01, 32'h02, 1'b1);
        checkOutput("sub_borrow_result", 0, 32'(if8.result), 32'hFF);
        checkOutput("sub_borrow_c_n", 0, {30'd0, if8.carry, if8.negative}, {30'd0, 2'b11});

        applyStimulus(0, 1'b1, ALU_MUL, 32'h10, 32'h20, 1'b1);
        checkOutput("mul_busy_in_ready", 0, 32'(if8.in_ready), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1'b0, ALU_ADD, 32'h0, 32'h0, 1'b1);
            if (k < 8) begin
                checkOutput("mul_busy_in_ready", 0, 32'(if8.in_ready), 32'd0);
                checkOutput("mul_busy_out_valid", 0, 32'(if8.out_valid), 32'd0);
            end
        end
        checkOutput("mul_out_valid", 0, 32'(if8.out_valid), 32'd1);
        checkOutput("mul_result", 0, 32'(if8.result), 32'h00);
        checkOutput("mul_c_z", 0, {30'd0, if8.carry, if8.zero}, {30'd0, 2'b11});

        applyStimulus(0, 1'b1, ALU_SHL, 32'h81, 32'h01, 1'b1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1'b1, ALU_OR, 32'h0F, 32'hF0, 1'b0);
            checkOutput("bp_result", 0, 32'(if8.result), 32'h02);
            checkOutput("bp_carry", 0, 32'(if8.carry), 32'd1);
            checkOutput("bp_in_ready", 0, 32'(if8.in_ready), 32'd0);
        end
        applyStimulus(0, 1'b1, ALU_OR, 32'h0F, 32'hF0, 1'b1);
        checkOutput("no_bubble_valid", 0, 32'(if8.out_valid), 32'd1);
        checkOutput("no_bubble_result", 0, 32'(if8.result), 32'hFF);
        applyStimulus(0, 1'b0, ALU_ADD, 32'h0, 32'h0, 1'b1);
        checkOutput("drain_out_valid", 0, 32'(if8.out_valid), 32'd0);

        applyStimulus(0, 1'b1, ALU_MUL, 32'h0F, 32'h0F, 1'b1);
        repeat (3) applyStimulus(0, 1'b0, ALU_ADD, 32'h0, 32'h0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 0, 32'(if8.out_valid), 32'd0);
        checkOutput("async_rst_result", 0, 32'(if8.result), 32'h00);
        checkOutput("async_rst_flags", 0,
                    {28'd0, if8.carry, if8.zero, if8.negative, if8.overflow}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 1'b1, ALU_XOR, 32'hAA, 32'hFF, 1'b1);
        checkOutput("post_rst_xor", 0, 32'(if8.result), 32'h55);
        repeat (12) applyStimulus(0, 1'b0, ALU_ADD, 32'h0, 32'h0, 1'b1);
        checkOutput("no_stale_mul", 0, 32'(if8.out_valid), 32'd0);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NDUT; i++) driveRandom(i, 1'b0, 1'b0);
            @(posedge clk);
            #1;
            for (int i = 0; i < NDUT; i++)
                checkOutput("stream_rate", i, 32'(out_valid_o[i]), 32'd1);
        end

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NDUT; i++) driveRandom(i, 1'b1, 1'b1);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < NDUT; i++) begin
            in_valid_d[i]  = 1'b0;
            out_ready_d[i] = 1'b1;
        end
        repeat (40) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; SHALL be legal for any power of two from 2 to 32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block accepts request this cycle.
REQ-006 Port: a  input  WIDTH  operand A (unsigned; two's complement for overflow flag).
REQ-007 Port: b  input  WIDTH  operand B; shift amount for shift ops.
REQ-008 Port: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 XOR, 100 OR, 101 SHL, 110 SHR, 111 MUL.
REQ-009 Port: out_valid  output  1  result and flags valid.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: result  output  WIDTH  registered result.
REQ-012 Port: carry  output  1  carry/borrow/shift-out/multiply-high flag.
REQ-013 Port: zero, negative, overflow  output  1 each  result==0; result[WIDTH-1]; signed overflow.

Function
REQ-014 Handshake: request accepted on a rising edge where in_valid && in_ready; result transferred where out_valid && out_ready.
REQ-015 in_ready SHALL be combinational: high when state is not BUSY and (out_valid low or out_ready high); back-to-back single-cycle ops SHALL sustain one per clock.
REQ-016 Single-cycle ops (ADD..SHR): accepted in cycle N -> out_valid high with result in cycle N+1.
REQ-017 ADD: {carry,result} = a + b (carry = bit WIDTH of the sum).
REQ-018 SUB: {carry,result} = a - b; carry = borrow (1 iff a < b unsigned).
REQ-019 AND/XOR/OR: bitwise; carry = 0.
REQ-020 SHL/SHR: logical shift by b[log2(WIDTH)-1:0]; carry = last bit shifted out; shift amount 0 -> result = a, carry = 0.
REQ-021 MUL: result = low WIDTH bits of a*b (unsigned); carry = 1 iff high WIDTH bits nonzero; iterative shift-add, WIDTH cycles in BUSY; out_valid at cycle N+WIDTH+1 after acceptance.
REQ-022 overflow: ADD/SUB signed two's-complement overflow; 0 for all other ops.
REQ-023 zero and negative SHALL be derived from the registered result for every op.
REQ-024 FSM states: IDLE (no result held), BUSY (MUL iterating), HOLD (out_valid high).
REQ-025 Transitions: IDLE/HOLD + accept single-cycle op -> HOLD; IDLE/HOLD + accept MUL -> BUSY; BUSY after WIDTH iterations -> HOLD; HOLD + out_ready and no accept -> IDLE.
REQ-026 While out_valid && !out_ready, result and all flags SHALL remain stable; no request accepted.
REQ-027 In BUSY, out_valid SHALL be low and in_ready low; inputs a, b, op ignored.
REQ-028 Same-edge transfer and accept in HOLD: old result leaves, new op's result (or BUSY) takes over without a bubble.
REQ-029 Opcode is fully decoded; no illegal-opcode case exists.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, out_valid 0, result 0, carry/zero/negative/overflow 0, multiplier state cleared.
REQ-031 Reset during BUSY SHALL abandon the multiply; no out_valid SHALL follow deassertion.
REQ-032 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-033 Package alu_pkg SHALL hold opcode constants (ALU_ADD..ALU_MUL) and FSM state type.
REQ-034 Sub-module alu_mul_seq SHALL implement the iterative shift-add multiplier (start, a, b -> done, product[2*WIDTH-1:0]).
REQ-035 Single-cycle datapath SHALL stay inline in alu_seq.

Verification
REQ-036 WIDTH=8, ADD a=0xFF b=0x01 -> result 0x00, carry 1, zero 1, overflow 0, out_valid one cycle after accept.
REQ-037 WIDTH=8, SUB a=0x80 b=0x01 -> result 0x7F, carry 0, overflow 1; SUB a=0x01 b=0x02 -> 0xFF, carry 1, negative 1.
REQ-038 WIDTH=8, MUL a=0x10 b=0x20 -> result 0x00, carry 1, zero 1, out_valid exactly 9 cycles after accept; in_ready low throughout.
REQ-039 Back-pressure: out_ready low for 5 cycles after SHL a=0x81 b=1 -> result 0x02, carry 1 held stable, in_ready low; then out_ready high with new op same edge -> no bubble.
REQ-040 Assert rst_n low mid-MUL (cycle 4) -> outputs 0 immediately; after release, XOR a=0xAA b=0xFF -> 0x55, no stale MUL result.
REQ-041 Stream 16 random single-cycle ops with out_ready=1 -> one result per clock, matched against a reference model, WIDTH 2 and 16.
